// File: rtl/muldiv_seq.sv
// Multi-cycle signed multiply/divide sequencer: shift-add multiply and restoring divide
// on unsigned magnitudes, with sign correction applied in a final fix-up cycle.
module muldiv_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] br_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] mr_out,
  output logic             ovf,
  output logic             dz
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StPrep, StRun, StFix, StDone} state_e;

  state_e             r_state, w_state_next;
  logic [CntW-1:0]    r_cnt;
  logic               r_is_mul, r_sa, r_sb;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_acc_out, r_mr_out;
  logic               r_ovf, r_dz;

  logic [WIDTH:0]     w_mul_sum, w_div_shift, w_div_diff;
  logic               w_div_ge, w_neg;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  // r_a holds the multiplicand, or the dividend that the quotient shifts into from the LSB.
  assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
  assign w_div_shift = {r_rem[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_neg       = r_sa ^ r_sb;
  assign w_prod_fix  = w_neg ? -r_prod : r_prod;
  assign w_quo_fix   = w_neg ? -r_a : r_a;
  assign w_rem_fix   = r_sa ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start_mul)      w_state_next = StPrep;
        else if (start_div) w_state_next = (br_in == '0) ? StDone : StPrep;
      end
      StPrep:  w_state_next = StRun;
      StRun:   if (r_cnt == LastCnt) w_state_next = StFix;
      StFix:   w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy = (r_state == StPrep) || (r_state == StRun) || (r_state == StFix);
    done = (r_state == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_is_mul  <= 1'b0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_prod    <= '0;
      r_rem     <= '0;
      r_acc_out <= '0;
      r_mr_out  <= '0;
      r_ovf     <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start_mul || start_div) begin
            r_a      <= acc_in;
            r_b      <= br_in;
            r_is_mul <= start_mul;
            if (!start_mul && (br_in == '0)) begin
              r_acc_out <= acc_in;
              r_mr_out  <= '0;
              r_ovf     <= 1'b0;
              r_dz      <= 1'b1;
            end
          end
        end
        StPrep: begin
          r_sa   <= r_a[WIDTH-1];
          r_sb   <= r_b[WIDTH-1];
          r_a    <= r_a[WIDTH-1] ? -r_a : r_a;
          r_b    <= r_b[WIDTH-1] ? -r_b : r_b;
          r_cnt  <= '0;
          r_prod <= '0;
          r_rem  <= '0;
        end
        StRun: begin
          r_cnt <= (r_cnt == LastCnt) ? '0 : r_cnt + 1'b1;
          if (r_is_mul) begin
            r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
            r_b    <= r_b >> 1;
          end else begin
            r_rem <= w_div_ge ? w_div_diff : w_div_shift;
            r_a   <= {r_a[WIDTH-2:0], w_div_ge};
          end
        end
        StFix: begin
          r_dz <= 1'b0;
          if (r_is_mul) begin
            r_acc_out <= w_prod_fix[WIDTH-1:0];
            r_mr_out  <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_ovf     <= (w_prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_fix[WIDTH-1]}});
          end else begin
            r_acc_out <= w_quo_fix;
            r_mr_out  <= w_rem_fix;
            // A positive quotient of magnitude 2^(WIDTH-1) only arises from MIN / -1.
            r_ovf     <= !w_neg && r_a[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign acc_out = r_acc_out;
  assign mr_out  = r_mr_out;
  assign ovf     = r_ovf;
  assign dz      = r_dz;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random operations against an
// arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_mul = 1'b0;
  logic        start_div = 1'b0;
  logic [15:0] acc_in = '0;
  logic [15:0] br_in = '0;
  logic        busy, done, ovf, dz;
  logic [15:0] acc_out, mr_out;

  int n_vec = 0;
  int n_miss = 0;

  muldiv_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_mul(start_mul),
    .start_div(start_div),
    .acc_in   (acc_in),
    .br_in    (br_in),
    .busy     (busy),
    .done     (done),
    .acc_out  (acc_out),
    .mr_out   (mr_out),
    .ovf      (ovf),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic m, input logic d, input logic [15:0] a,
                        input logic [15:0] b, input bit poke, input string tag);
    int sa, sb, q, r, cyc, busy_n, done_at, extra;
    longint p;
    logic [15:0] e_acc, e_mr;
    logic e_ovf, e_dz;
    int e_lat, e_busy;
    sa = $signed(a);
    sb = $signed(b);
    e_dz = 1'b0;
    e_ovf = 1'b0;
    e_lat = 19;
    e_busy = 18;
    if (m) begin
      p = longint'(sa) * longint'(sb);
      e_acc = p[15:0];
      e_mr = p[31:16];
      e_ovf = (p > 32767) || (p < -32768);
    end else if (sb == 0) begin
      e_acc = a;
      e_mr = '0;
      e_dz = 1'b1;
      e_lat = 1;
      e_busy = 0;
    end else if (sa == -32768 && sb == -1) begin
      e_acc = 16'h8000;
      e_mr = '0;
      e_ovf = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e_acc = q[15:0];
      e_mr = r[15:0];
    end

    @(posedge clk); #1;
    start_mul = m; start_div = d; acc_in = a; br_in = b;
    @(posedge clk); #1;
    start_mul = 1'b0; start_div = 1'b0;
    acc_in = 16'($urandom); br_in = 16'($urandom);
    cyc = 1; busy_n = 0; done_at = 0;
    while (done_at == 0 && cyc < 40) begin
      if (busy) busy_n++;
      if (done) done_at = cyc;
      else begin
        if (poke && cyc == 5) begin start_mul = 1'b1; start_div = 1'b1; end
        if (poke && cyc == 6) begin start_mul = 1'b0; start_div = 1'b0; end
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, " latency"}, done_at, e_lat);
    chk({tag, " busy_cycles"}, busy_n, e_busy);
    chk({tag, " busy_at_done"}, busy, 1'b0);
    chk({tag, " acc_out"}, acc_out, e_acc);
    chk({tag, " mr_out"}, mr_out, e_mr);
    chk({tag, " ovf"}, ovf, e_ovf);
    chk({tag, " dz"}, dz, e_dz);
    @(posedge clk); #1;
    chk({tag, " done_single"}, done, 1'b0);
    if (poke) begin
      extra = 0;
      repeat (25) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      chk({tag, " no_extra_done"}, extra, 0);
      chk({tag, " acc_held"}, acc_out, e_acc);
      chk({tag, " mr_held"}, mr_out, e_mr);
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic rm;
    #12;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst acc_out", acc_out, 16'h0);
    chk("rst mr_out", mr_out, 16'h0);
    chk("rst ovf", ovf, 1'b0);
    chk("rst dz", dz, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    run_op(1'b1, 1'b0, 16'h0007, 16'hFFFD, 1'b0, "mul 7*-3");
    run_op(1'b1, 1'b0, 16'h4000, 16'h0004, 1'b0, "mul ovf");
    run_op(1'b0, 1'b1, 16'hFFF9, 16'h0002, 1'b0, "div -7/2");
    run_op(1'b0, 1'b1, 16'h0007, 16'hFFFE, 1'b0, "div 7/-2");
    run_op(1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, "div by zero");
    run_op(1'b0, 1'b1, 16'h8000, 16'hFFFF, 1'b1, "div min/-1");
    run_op(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0, "both starts mul");
    run_op(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b0, "div min/1");

    // Abort a multiply during its fifth RUN cycle.
    @(posedge clk); #1;
    start_mul = 1'b1; acc_in = 16'h1234; br_in = 16'h0567;
    @(posedge clk); #1;
    start_mul = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort acc_out", acc_out, 16'h0);
    chk("abort mr_out", mr_out, 16'h0);
    chk("abort ovf", ovf, 1'b0);
    chk("abort dz", dz, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("abort no done", done, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    run_op(1'b1, 1'b0, 16'h0003, 16'h0005, 1'b0, "mul 3*5 after reset");

    for (int i = 0; i < 40; i++) begin
      rm = 1'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'h0000;
        1: rb = 16'hFFFF;
        2: begin ra = 16'h8000; rb = 16'hFFFF; end
        3: rb = 16'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rm, ~rm, ra, rb, 1'b0, rm ? "rand mul" : "rand div");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
